seq_updown_cnt: RTL and testbench

Parametrised up/down modulo counter with direction input, synchronous load, enable, programmable match detect and wrap pulse. It succeeds the fixed 2-bit up/down detector in the basic sequential library. It generalises width and modulus, adds load, enable and event outputs, and optionally supports saturation. It is used as a reusable sequence/position counter in the basic circuit set and in small control FSMs.

---
 rtl/seq_udc_pkg.sv | 22 ++
 rtl/seq_udc_next.sv | 75 +++++++
 rtl/seq_updown_cnt.sv | 62 ++++++
 tb/tb_seq_updown_cnt.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_udc_pkg.sv
// Shared types and elaboration helpers for the up/down modulo counter.
// Optional saturate mode is enabled by defining SEQ_UDC_SAT_EN.
package seq_udc_pkg;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // True when 2 <= m <= 2**w, i.e. MOD-1 fits in a w-bit count.
   function automatic bit udc_mod_ok(
      input int unsigned     w,
      input longint unsigned m
   );
      if (w == 0 || m < 2)
         return 1'b0;
      if (w >= 63)
         return 1'b1;
      return m <= (64'd1 << w);
   endfunction

endpackage

// File: rtl/seq_udc_next.sv
// Next-count and wrap-flag logic for seq_updown_cnt.
// The sat input exists only when SEQ_UDC_SAT_EN is defined.
module seq_udc_next
   import seq_udc_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  logic [WIDTH-1:0] cnt,
   input  logic             en,
   input  dir_e             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`ifdef SEQ_UDC_SAT_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] cnt_next,
   output logic             wrap_next
);

   localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MOD);
   localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MOD - 1);
   localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] ZERO  = '0;

   logic             sat_on;
   logic [WIDTH:0]   ext;
   logic [WIDTH:0]   ld;
   logic [WIDTH:0]   inc;
   logic [WIDTH:0]   dec;

`ifdef SEQ_UDC_SAT_EN
   assign sat_on = sat;
`else
   assign sat_on = 1'b0;
`endif

   // Extra bit keeps the modulus compare and borrow ahead of truncation.
   assign ext = {1'b0, cnt};
   assign ld  = {1'b0, load_val};
   assign inc = ext + ONE_X;
   assign dec = ext - ONE_X;

   always_comb begin
      cnt_next  = cnt;
      wrap_next = 1'b0;
      unique case (1'b1)
         load: begin
            cnt_next = (ld > MAX_X) ? MAX_C : load_val;
         end
         (!load && en && dir == DIR_UP): begin
            if (inc >= MOD_X) begin
               cnt_next  = sat_on ? MAX_C : ZERO;
               wrap_next = !sat_on;
            end else begin
               cnt_next = inc[WIDTH-1:0];
            end
         end
         (!load && en && dir == DIR_DOWN): begin
            if (dec[WIDTH]) begin
               cnt_next  = sat_on ? ZERO : MAX_C;
               wrap_next = !sat_on;
            end else begin
               cnt_next = dec[WIDTH-1:0];
            end
         end
         default: begin
            cnt_next  = cnt;
            wrap_next = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seq_updown_cnt.sv
// Parametrised up/down modulo counter with load, match hit and wrap pulse.
// Define SEQ_UDC_SAT_EN to add the sat port and saturating mode.
module seq_updown_cnt
   import seq_udc_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] match_val,
`ifdef SEQ_UDC_SAT_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] cnt,
   output logic             hit,
   output logic             wrap
);

   generate
      if (!udc_mod_ok(WIDTH, MOD)) begin : g_bad_mod
         $error("seq_updown_cnt: MOD must satisfy 2 <= MOD <= 2**WIDTH");
      end
   endgenerate

   logic [WIDTH-1:0] cnt_next;
   logic             wrap_next;

   seq_udc_next #(
      .WIDTH (WIDTH),
      .MOD   (MOD)
   ) u_next (
      .cnt       (cnt),
      .en        (en),
      .dir       (dir_e'(dir)),
      .load      (load),
      .load_val  (load_val),
`ifdef SEQ_UDC_SAT_EN
      .sat       (sat),
`endif
      .cnt_next  (cnt_next),
      .wrap_next (wrap_next)
   );

   // cnt_next never exceeds MOD-1, so an out-of-range match_val cannot hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         hit  <= 1'b0;
         wrap <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         hit  <= (cnt_next == match_val);
         wrap <= wrap_next;
      end
   end

endmodule

// File: tb/tb_seq_updown_cnt.sv
// Directed self-checking bench for seq_updown_cnt (WIDTH=4, MOD=10).
// Saturate steps run only when SEQ_UDC_SAT_EN is defined.
module tb_seq_updown_cnt;

   localparam int WIDTH = 4;
   localparam int MOD   = 10;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] match_val;
`ifdef SEQ_UDC_SAT_EN
   logic             sat;
`endif
   logic [WIDTH-1:0] cnt;
   logic             hit;
   logic             wrap;

   int checks   = 0;
   int failures = 0;

   seq_updown_cnt #(
      .WIDTH (WIDTH),
      .MOD   (MOD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .dir       (dir),
      .load      (load),
      .load_val  (load_val),
      .match_val (match_val),
`ifdef SEQ_UDC_SAT_EN
      .sat       (sat),
`endif
      .cnt       (cnt),
      .hit       (hit),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input int c, input bit h,
                       input bit w);
      chk({tag, ".cnt"}, 32'(cnt), c);
      chk({tag, ".hit"}, 32'(hit), 32'(h));
      chk({tag, ".wrap"}, 32'(wrap), 32'(w));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      dir       = 1'b0;
      load      = 1'b0;
      load_val  = '0;
      match_val = 4'd15;
`ifdef SEQ_UDC_SAT_EN
      sat       = 1'b0;
`endif
      #12;
      chk3("reset", 0, 0, 0);
      rst_n = 1'b1;

      // Up count 1..9 then wrap to 0
      en = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("up.cnt", 32'(cnt), i % 10);
         chk("up.wrap", 32'(wrap), (i == 10) ? 1 : 0);
      end

      // Down wrap, then direction change at 8
      dir = 1'b1;
      tick();
      chk3("down0", 9, 0, 1);
      tick();
      chk3("down1", 8, 0, 0);
      dir = 1'b0;
      tick();
      chk3("dirflip", 9, 0, 0);

      // Load clamp and load priority over enable
      load     = 1'b1;
      en       = 1'b0;
      load_val = 4'd12;
      tick();
      chk3("ldclamp", 9, 0, 0);
      en       = 1'b1;
      load_val = 4'd5;
      tick();
      chk3("ldpri", 5, 0, 0);

      // Match detect
      load_val = 4'd0;
      tick();
      chk3("ld0", 0, 0, 0);
      load      = 1'b0;
      match_val = 4'd3;
      tick();
      chk3("m1", 1, 0, 0);
      tick();
      chk3("m2", 2, 0, 0);
      tick();
      chk3("m3", 3, 1, 0);
      en = 1'b0;
      tick();
      chk3("mhold", 3, 1, 0);
      match_val = 4'd4;
      #1;
      chk("mreg.hit", 32'(hit), 1);
      tick();
      chk3("mdrop", 3, 0, 0);

      // Out-of-range match_val never hits
      match_val = 4'd12;
      load      = 1'b1;
      load_val  = 4'd15;
      tick();
      chk3("mrange", 9, 0, 0);

      // Async reset mid-count
      load_val = 4'd6;
      tick();
      load = 1'b0;
      en   = 1'b1;
      tick();
      chk3("pre_rst", 7, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk3("async_rst", 0, 0, 0);
      #2;
      rst_n = 1'b1;
      tick();
      chk3("post_rst", 1, 0, 0);

`ifdef SEQ_UDC_SAT_EN
      load     = 1'b1;
      load_val = 4'd8;
      tick();
      load = 1'b0;
      sat  = 1'b1;
      tick();
      chk3("sat9a", 9, 0, 0);
      tick();
      chk3("sat9b", 9, 0, 0);
      tick();
      chk3("sat9c", 9, 0, 0);
      sat = 1'b0;
      tick();
      chk3("unsat", 0, 0, 1);
      sat = 1'b1;
      dir = 1'b1;
      tick();
      chk3("sat0", 0, 0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
